// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared constants for the UART receive FIFO controller:
//   - irqId encodings (IRQ_NONE, IRQ_LINE, IRQ_DATA, IRQ_TIMEOUT)
//   - flag bit indices within rdFlags and lineStatus
//   - trigger-level decode constants (1, 4, 8, 14 entries)
//   - FIFO entry width ({break, parity, frame, data[7:0]} = 11 bits)
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 3;
    localparam int ENTRY_W = DATA_W + FLAG_W;

    // Bit positions inside rdFlags / the flag field of an entry
    localparam int FLAG_FRAME  = 0;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_BREAK  = 2;

    // Bit positions inside lineStatus
    localparam int LS_FRAME   = 0;
    localparam int LS_PARITY  = 1;
    localparam int LS_BREAK   = 2;
    localparam int LS_OVERRUN = 3;

    localparam logic [4:0] TRIG_1  = 5'd1;
    localparam logic [4:0] TRIG_4  = 5'd4;
    localparam logic [4:0] TRIG_8  = 5'd8;
    localparam logic [4:0] TRIG_14 = 5'd14;

    typedef enum logic [1:0] {
        IRQ_NONE    = 2'd0,
        IRQ_LINE    = 2'd1,
        IRQ_DATA    = 2'd2,
        IRQ_TIMEOUT = 2'd3
    } irqId_t;

    function automatic logic [4:0] triggerDecode(input logic [1:0] level);
        logic [4:0] value;
        unique case (level)
            2'd0:    value = TRIG_1;
            2'd1:    value = TRIG_4;
            2'd2:    value = TRIG_8;
            default: value = TRIG_14;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl_if
// Groups the receiver write side and the CPU read side of the receive FIFO.
//   Receiver -> FIFO : rxWe, rxData, rxFrameError, rxParityError, rxBreak,
//                      rxOverrun
//   FIFO -> receiver : fifoFull
//   CPU -> FIFO      : readAck
//   FIFO -> CPU      : rdData, rdFlags, dataReady
// Modports: master = the receiver/CPU side, slave = the FIFO controller.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_ctrl_if;
    import uart_rx_pkg::*;

    logic              rxWe;
    logic [DATA_W-1:0] rxData;
    logic              rxFrameError;
    logic              rxParityError;
    logic              rxBreak;
    logic              rxOverrun;
    logic              fifoFull;
    logic              readAck;
    logic [DATA_W-1:0] rdData;
    logic [FLAG_W-1:0] rdFlags;
    logic              dataReady;

    modport master (
        output rxWe, rxData, rxFrameError, rxParityError, rxBreak, rxOverrun,
        output readAck,
        input  fifoFull, rdData, rdFlags, dataReady
    );

    modport slave (
        input  rxWe, rxData, rxFrameError, rxParityError, rxBreak, rxOverrun,
        input  readAck,
        output fifoFull, rdData, rdFlags, dataReady
    );

endinterface

// File: rtl/uart_rx_fifo_ctrl_mem.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_mem
// Storage, pointers and occupancy count of the receive FIFO.
//   clock, reset   : system clock, asynchronous active-low reset
//   wrEn, wrEntry  : push request and entry
//   rdEn           : pop request
//   clear          : synchronous flush, wins over push/pop
//   headEntry      : show-ahead head entry (don't-care when empty)
//   count          : occupancy, DEPTH_LOG2+1 bits
//   full, empty    : occupancy flags
//   pushOk, popOk  : accepted push / pop this cycle
// Full is judged on the pre-pop count, so a push into a full FIFO is dropped
// even if a pop happens in the same cycle; a pop from an empty FIFO is
// ignored even if a push happens in the same cycle.
// -----------------------------------------------------------------------------
module uart_rx_fifo_mem
    import uart_rx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wrEn,
    input  logic [ENTRY_W-1:0]   wrEntry,
    input  logic                 rdEn,
    input  logic                 clear,
    output logic [ENTRY_W-1:0]   headEntry,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 full,
    output logic                 empty,
    output logic                 pushOk,
    output logic                 popOk
);

    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [ENTRY_W-1:0]    storage [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;

    // count never exceeds the depth, so its MSB alone marks full
    assign full   = count[DEPTH_LOG2];
    assign empty  = (count == '0);
    assign pushOk = wrEn && !full;
    assign popOk  = rdEn && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
            count <= count + CNT_W'(pushOk) - CNT_W'(popOk);
        end
    end

    always_ff @(posedge clock) begin
        if (pushOk && !clear) storage[wrPtr] <= wrEntry;
    end

    assign headEntry = storage[rdPtr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// Receive-side buffer and interrupt controller between the UART receiver and
// the CPU register file.
//   clock, reset     : system clock, asynchronous active-low reset
//   baudRateX16Tick  : 16x baud strobe for the character timeout
//   rxIf (slave)     : receiver write side + CPU show-ahead read side
//   fifoClear        : synchronous flush pulse (sticky bits kept)
//   triggerLevel     : data interrupt threshold 0:1, 1:4, 2:8, 3:14
//   rxIrqEnable      : enables data and timeout interrupts
//   lineIrqEnable    : enables the line-status interrupt
//   lsrRead          : clears sticky line status
//   lineStatus       : {overrun, break, parity, frame} sticky bits
//   fifoErrPending   : some stored entry carries an error flag
//   irq, irqId       : registered prioritised interrupt (line > data > timeout)
// Build option: define UART_RX_TIMEOUT_EN to include the character timeout
// counter and the timeout interrupt (irqId 3).
// -----------------------------------------------------------------------------
module uart_rx_fifo_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                baudRateX16Tick,
    uart_rx_fifo_ctrl_if.slave  rxIf,
    input  logic                fifoClear,
    input  logic [1:0]          triggerLevel,
    input  logic                rxIrqEnable,
    input  logic                lineIrqEnable,
    input  logic                lsrRead,
    output logic [3:0]          lineStatus,
    output logic                fifoErrPending,
    output logic                irq,
    output logic [1:0]          irqId
);

    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [ENTRY_W-1:0] wrEntry;
    logic [ENTRY_W-1:0] headEntry;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               pushOk;
    logic               popOk;

    assign wrEntry = {rxIf.rxBreak, rxIf.rxParityError, rxIf.rxFrameError, rxIf.rxData};

    uart_rx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) fifoMem (
        .clock     (clock),
        .reset     (reset),
        .wrEn      (rxIf.rxWe),
        .wrEntry   (wrEntry),
        .rdEn      (rxIf.readAck),
        .clear     (fifoClear),
        .headEntry (headEntry),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .pushOk    (pushOk),
        .popOk     (popOk)
    );

    assign rxIf.fifoFull  = full;
    assign rxIf.dataReady = !empty;
    assign rxIf.rdData    = headEntry[DATA_W-1:0];
    assign rxIf.rdFlags   = headEntry[DATA_W +: FLAG_W];

    // ---------------- error-entry count ----------------
    logic [CNT_W-1:0] errCount;
    logic             pushErr;
    logic             popErr;

    assign pushErr = pushOk && (|wrEntry[DATA_W +: FLAG_W]);
    assign popErr  = popOk && (|headEntry[DATA_W +: FLAG_W]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            errCount <= '0;
        end else if (fifoClear) begin
            errCount <= '0;
        end else if (pushErr && !popErr) begin
            errCount <= errCount + 1'b1;
        end else if (popErr && !pushErr) begin
            errCount <= errCount - 1'b1;
        end
    end

    assign fifoErrPending = (errCount != '0);

    // ---------------- sticky line status ----------------
    logic       rxOverrunQ;
    logic [3:0] stickySet;

    always_comb begin
        stickySet             = '0;
        stickySet[LS_FRAME]   = pushOk && rxIf.rxFrameError;
        stickySet[LS_PARITY]  = pushOk && rxIf.rxParityError;
        stickySet[LS_BREAK]   = pushOk && rxIf.rxBreak;
        stickySet[LS_OVERRUN] = (rxIf.rxWe && full) || (rxIf.rxOverrun && !rxOverrunQ);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxOverrunQ <= 1'b0;
            lineStatus <= '0;
        end else begin
            rxOverrunQ <= rxIf.rxOverrun;
            // a new event in the same cycle as the LSR read survives the clear
            lineStatus <= lsrRead ? stickySet : (lineStatus | stickySet);
        end
    end

    // ---------------- character timeout ----------------
    logic timeoutPending;

`ifdef UART_RX_TIMEOUT_EN
    localparam int              TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);

    logic [TO_W-1:0] timeoutCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeoutCnt <= '0;
        end else if (fifoClear || pushOk || popOk || empty) begin
            timeoutCnt <= '0;
        end else if (baudRateX16Tick && (timeoutCnt != TO_MAX)) begin
            timeoutCnt <= timeoutCnt + 1'b1;
        end
    end

    assign timeoutPending = (timeoutCnt == TO_MAX) && !empty;
`else
    localparam int unusedTimeoutTicks = TIMEOUT_TICKS;
    logic          unusedTick;

    assign unusedTick     = baudRateX16Tick;
    assign timeoutPending = 1'b0;
`endif

    // ---------------- prioritised interrupt ----------------
    logic [CNT_W-1:0] trigValue;
    irqId_t           irqNext;

    assign trigValue = CNT_W'(triggerDecode(triggerLevel));

    always_comb begin
        irqNext = IRQ_NONE;
        if (lineIrqEnable && ((|lineStatus) || fifoErrPending)) begin
            irqNext = IRQ_LINE;
        end else if (rxIrqEnable && (count >= trigValue)) begin
            irqNext = IRQ_DATA;
        end else if (rxIrqEnable && timeoutPending) begin
            irqNext = IRQ_TIMEOUT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq   <= 1'b0;
            irqId <= IRQ_NONE;
        end else begin
            irq   <= (irqNext != IRQ_NONE);
            irqId <= irqNext;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Self-checking bench for uart_rx_fifo_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// Honours UART_RX_TIMEOUT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;
    import uart_rx_pkg::*;

    localparam int DEPTH_LOG2    = 4;
    localparam int DEPTH         = 16;
    localparam int TIMEOUT_TICKS = 640;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       baudRateX16Tick;
    logic       fifoClear;
    logic [1:0] triggerLevel;
    logic       rxIrqEnable;
    logic       lineIrqEnable;
    logic       lsrRead;
    logic [3:0] lineStatus;
    logic       fifoErrPending;
    logic       irq;
    logic [1:0] irqId;

    uart_rx_fifo_ctrl_if rxIf ();

    uart_rx_fifo_ctrl #(
        .DEPTH_LOG2    (DEPTH_LOG2),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .baudRateX16Tick (baudRateX16Tick),
        .rxIf            (rxIf),
        .fifoClear       (fifoClear),
        .triggerLevel    (triggerLevel),
        .rxIrqEnable     (rxIrqEnable),
        .lineIrqEnable   (lineIrqEnable),
        .lsrRead         (lsrRead),
        .lineStatus      (lineStatus),
        .fifoErrPending  (fifoErrPending),
        .irq             (irq),
        .irqId           (irqId)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [10:0] mq[$];        // {break, parity, frame, data}
    logic [3:0]  mSticky;
    logic        mPrevOvr;
    int          mTimeout;
    int          mIrqId;

    function automatic int trigOf(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    function automatic bit modelErrPending();
        foreach (mq[i]) if (mq[i][10:8] != 3'b000) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mq.delete();
        mSticky  = 4'h0;
        mPrevOvr = 1'b0;
        mTimeout = 0;
        mIrqId   = 0;
    endtask

    task automatic idleInputs();
        rxIf.rxWe          = 1'b0;
        rxIf.rxFrameError  = 1'b0;
        rxIf.rxParityError = 1'b0;
        rxIf.rxBreak       = 1'b0;
        rxIf.readAck       = 1'b0;
        fifoClear          = 1'b0;
        lsrRead            = 1'b0;
        baudRateX16Tick    = 1'b0;
    endtask

    task automatic checkOutputs();
        checkVal("fifoFull", rxIf.fifoFull, mq.size() == DEPTH);
        checkVal("dataReady", rxIf.dataReady, mq.size() != 0);
        if (mq.size() != 0) begin
            checkVal("rdData", rxIf.rdData, mq[0][7:0]);
            checkVal("rdFlags", rxIf.rdFlags, mq[0][10:8]);
        end
        checkVal("lineStatus", lineStatus, mSticky);
        checkVal("fifoErrPending", fifoErrPending, modelErrPending());
        checkVal("irq", irq, mIrqId != 0);
        checkVal("irqId", irqId, mIrqId);
    endtask

    // Apply the currently driven inputs for one clock and check the result.
    task automatic stepCycle();
        bit   full, empty, pushOk, popOk, dropped, toPend;
        logic [3:0] setBits;
        full    = (mq.size() == DEPTH);
        empty   = (mq.size() == 0);
        pushOk  = rxIf.rxWe && !full;
        popOk   = rxIf.readAck && !empty;
        dropped = rxIf.rxWe && full;
        toPend  = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        toPend  = (mTimeout == TIMEOUT_TICKS) && !empty;
`endif
        if (lineIrqEnable && (mSticky != 0 || modelErrPending()))  mIrqId = 1;
        else if (rxIrqEnable && mq.size() >= trigOf(triggerLevel)) mIrqId = 2;
        else if (rxIrqEnable && toPend)                            mIrqId = 3;
        else                                                       mIrqId = 0;

        setBits = {dropped || (rxIf.rxOverrun && !mPrevOvr),
                   pushOk && rxIf.rxBreak,
                   pushOk && rxIf.rxParityError,
                   pushOk && rxIf.rxFrameError};
        mSticky  = lsrRead ? setBits : (mSticky | setBits);
        mPrevOvr = rxIf.rxOverrun;

        if (fifoClear || pushOk || popOk || empty) mTimeout = 0;
        else if (baudRateX16Tick && mTimeout < TIMEOUT_TICKS) mTimeout++;

        if (fifoClear) begin
            mq.delete();
        end else begin
            if (popOk)  void'(mq.pop_front());
            if (pushOk) mq.push_back({rxIf.rxBreak, rxIf.rxParityError, rxIf.rxFrameError, rxIf.rxData});
        end

        @(posedge clock);
        #1;
        checkOutputs();
        idleInputs();
    endtask

    task automatic pushChar(input logic [7:0] d, input logic fe, input logic pe, input logic brk);
        rxIf.rxWe          = 1'b1;
        rxIf.rxData        = d;
        rxIf.rxFrameError  = fe;
        rxIf.rxParityError = pe;
        rxIf.rxBreak       = brk;
        stepCycle();
    endtask

    task automatic popChar();
        rxIf.readAck = 1'b1;
        stepCycle();
    endtask

    task automatic drainAll();
        for (int unsigned i = 0; i < 40 && mq.size() != 0; i++) popChar();
    endtask

    task automatic tickCycles(input int n);
        for (int i = 0; i < n; i++) begin
            baudRateX16Tick = 1'b1;
            stepCycle();
        end
    endtask

    initial begin
        idleInputs();
        rxIf.rxData    = 8'h00;
        rxIf.rxOverrun = 1'b0;
        triggerLevel   = 2'd0;
        rxIrqEnable    = 1'b0;
        lineIrqEnable  = 1'b0;
        modelReset();

        // ---- reset state ----
        repeat (2) @(posedge clock);
        #1;
        checkOutputs();
        @(negedge clock);
        reset = 1'b1;

        // ---- single character, data interrupt and its release ----
        rxIrqEnable = 1'b1;
        pushChar(8'h41, 1'b0, 1'b0, 1'b0);
        checkVal("t1_dataReady", rxIf.dataReady, 1);
        checkVal("t1_rdData", rxIf.rdData, 8'h41);
        stepCycle();
        checkVal("t1_irqId", irqId, IRQ_DATA);
        popChar();
        stepCycle();
        checkVal("t1_irqOff", irq, 0);

        // ---- fill to full, overflow, line interrupt, LSR read ----
        triggerLevel  = 2'd3;
        lineIrqEnable = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushChar(8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        pushChar(8'hEE, 1'b0, 1'b0, 1'b0);
        checkVal("t2_full", rxIf.fifoFull, 1);
        checkVal("t2_overrun", lineStatus[LS_OVERRUN], 1);
        stepCycle();
        checkVal("t2_irqLine", irqId, IRQ_LINE);
        lsrRead = 1'b1;
        stepCycle();
        checkVal("t2_lsrClear", lineStatus, 0);
        stepCycle();
        checkVal("t2_irqData", irqId, IRQ_DATA);
        checkVal("t2_head", rxIf.rdData, 8'h80);
        drainAll();

        // ---- per-entry error flags ----
        lineIrqEnable = 1'b0;
        pushChar(8'h55, 1'b0, 1'b1, 1'b0);
        pushChar(8'h66, 1'b0, 1'b0, 1'b0);
        checkVal("t3_errPend", fifoErrPending, 1);
        checkVal("t3_flags", rxIf.rdFlags, 3'b010);
        popChar();
        checkVal("t3_errClr", fifoErrPending, 0);
        checkVal("t3_flagsClr", rxIf.rdFlags, 3'b000);
        checkVal("t3_data", rxIf.rdData, 8'h66);
        lsrRead = 1'b1;
        stepCycle();
        drainAll();

        // ---- character timeout ----
        triggerLevel = 2'd3;
        pushChar(8'h01, 1'b0, 1'b0, 1'b0);
        pushChar(8'h02, 1'b0, 1'b0, 1'b0);
        tickCycles(TIMEOUT_TICKS + 1);
`ifdef UART_RX_TIMEOUT_EN
        checkVal("t4_timeout", irqId, IRQ_TIMEOUT);
`else
        checkVal("t4_noTimeout", irqId, IRQ_NONE);
`endif
        popChar();
        stepCycle();
        checkVal("t4_released", irq, 0);
        tickCycles(TIMEOUT_TICKS + 1);
`ifdef UART_RX_TIMEOUT_EN
        checkVal("t4_timeoutAgain", irqId, IRQ_TIMEOUT);
`else
        checkVal("t4_noTimeoutAgain", irqId, IRQ_NONE);
`endif
        drainAll();

        // ---- simultaneous push and pop at full and at empty ----
        for (int i = 0; i < DEPTH; i++) pushChar(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        rxIf.readAck = 1'b1;
        pushChar(8'hAA, 1'b0, 1'b0, 1'b0);
        checkVal("t5_notFull", rxIf.fifoFull, 0);
        checkVal("t5_head", rxIf.rdData, 8'h21);
        drainAll();
        rxIf.readAck = 1'b1;
        pushChar(8'hBB, 1'b0, 1'b0, 1'b0);
        checkVal("t5_emptyBoth", rxIf.dataReady, 1);
        checkVal("t5_emptyData", rxIf.rdData, 8'hBB);
        drainAll();
        lsrRead = 1'b1;
        stepCycle();

        // ---- flush keeps sticky bits; reset mid-fill ----
        rxIf.rxOverrun = 1'b1;
        stepCycle();
        rxIf.rxOverrun = 1'b0;
        pushChar(8'h11, 1'b1, 1'b0, 1'b0);
        pushChar(8'h12, 1'b0, 1'b0, 1'b0);
        pushChar(8'h13, 1'b0, 1'b0, 1'b0);
        fifoClear = 1'b1;
        pushChar(8'h14, 1'b0, 1'b0, 1'b0);
        checkVal("t6_cleared", rxIf.dataReady, 0);
        checkVal("t6_sticky", lineStatus, 4'b1001);
        checkVal("t6_errClr", fifoErrPending, 0);
        for (int i = 0; i < 5; i++) pushChar(8'(8'h30 + i), 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutputs();
        @(negedge clock);
        reset = 1'b1;

        // ---- randomized traffic ----
        for (int phase = 0; phase < 16; phase++) begin
            int pushPct, popPct;
            pushPct       = $urandom_range(20, 90);
            popPct        = $urandom_range(20, 90);
            triggerLevel  = 2'($urandom_range(0, 3));
            rxIrqEnable   = 1'($urandom_range(0, 1));
            lineIrqEnable = 1'($urandom_range(0, 1));
            for (int c = 0; c < 200; c++) begin
                rxIf.rxWe          = ($urandom_range(0, 99) < pushPct);
                rxIf.rxData        = 8'($urandom);
                rxIf.rxFrameError  = ($urandom_range(0, 15) == 0);
                rxIf.rxParityError = ($urandom_range(0, 15) == 0);
                rxIf.rxBreak       = ($urandom_range(0, 31) == 0);
                rxIf.readAck       = ($urandom_range(0, 99) < popPct);
                if ($urandom_range(0, 19) == 0) rxIf.rxOverrun = ~rxIf.rxOverrun;
                fifoClear          = ($urandom_range(0, 99) == 0);
                lsrRead            = ($urandom_range(0, 24) == 0);
                baudRateX16Tick    = ($urandom_range(0, 1) == 1);
                stepCycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Receive-side buffer and interrupt controller that sits between the UART receiver and the CPU bus register file. It stores received characters together with their per-character error flags in a FIFO. It drives the receiver's fifoFull back-pressure and accumulates sticky line status. It raises a prioritised interrupt for line errors, trigger-level reached and character timeout.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
TIMEOUT_TICKS, 640, baudRateX16Tick count for the character timeout (4 chars x 10 bits x 16).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
baudRateX16Tick  in  1  16x baud strobe, one clock wide
rxWe  in  1  receiver write strobe
rxData  in  8  received character
rxFrameError  in  1  frame error, valid with rxWe
rxParityError  in  1  parity error, valid with rxWe
rxBreak  in  1  break detected, valid with rxWe
rxOverrun  in  1  receiver overrun level
fifoFull  out  1  to receiver; count == depth
readAck  in  1  CPU pop of head entry
rdData  out  8  head character (show-ahead)
rdFlags  out  3  head flags {break, parity, frame}
dataReady  out  1  FIFO not empty
fifoClear  in  1  synchronous flush pulse
triggerLevel  in  2  0:1, 1:4, 2:8, 3:14 entries
rxIrqEnable  in  1  enables data and timeout interrupts
lineIrqEnable  in  1  enables line-status interrupt
lsrRead  in  1  clears sticky line status
lineStatus  out  4  {overrunSticky, breakSticky, parSticky, frameSticky}
fifoErrPending  out  1  any stored entry carries an error flag
irq  out  1  interrupt request, registered
irqId  out  2  0 none, 1 line, 2 data, 3 timeout

Behaviour:
- Reset: pointers, count, errCount and timeout counter are 0. All sticky bits, irq and irqId are 0. fifoFull=0, dataReady=0. Storage contents are don't-care.
- Push: occurs when rxWe=1 and the pre-pop count < depth. An entry is {rxBreak, rxParityError, rxFrameError, rxData}. A push while full is dropped and sets overrunSticky.
- Pop: occurs when readAck=1 and count > 0. A pop when empty is ignored.
- Simultaneous push and pop:
  - full: pop succeeds, push is dropped (full is evaluated before the pop).
  - empty: push succeeds, pop is ignored.
  - otherwise: count is unchanged.
- Pointers wrap modulo depth. count is DEPTH_LOG2+1 bits wide.
- rdData and rdFlags show the head entry combinationally from storage. When empty they are don't-care; the bench checks them only when dataReady=1.
- errCount counts stored entries with any flag set: +1 on a push with any flag, -1 on a pop of an entry with any flag, net 0 when both happen in one cycle. fifoErrPending = (errCount != 0).
- Sticky bits:
  - frame/parity/break sticky bits set on a push carrying the matching flag.
  - overrunSticky sets on a rising edge of rxOverrun or on a dropped push.
  - lsrRead clears all four sticky bits. A set in the same cycle as lsrRead wins.
- fifoClear: next clock, count, pointers, errCount and the timeout counter are 0. Sticky bits are unaffected. fifoClear wins over a push or pop in the same cycle.
- Timeout counter:
  - Cleared on any push, any pop, fifoClear, or when empty.
  - Otherwise it increments on baudRateX16Tick and saturates at TIMEOUT_TICKS.
  - timeoutPending = (counter == TIMEOUT_TICKS) and not empty.
- Interrupt priority, evaluated combinationally and registered into irq/irqId (1-cycle latency):
  1. line: lineIrqEnable and (any sticky bit or fifoErrPending).
  2. data: rxIrqEnable and count >= trigger value.
  3. timeout: rxIrqEnable and timeoutPending.
  4. none: irq=0, irqId=0.
- The interrupt deasserts one cycle after its cause clears: pop below trigger, lsrRead, or a pop that resets the timeout.
- A reset mid-operation aborts immediately; contents are lost.

Optional Feature:
UART_RX_TIMEOUT_EN.
- Defined: timeout counter and timeout interrupt (irqId 3) as above.
- Undefined: no counter; timeoutPending is tied 0 and irqId never equals 3. baudRateX16Tick is unused. All other behaviour is unchanged.

Decomposition:
- Package uart_rx_pkg holds:
  - irqId constants (IRQ_NONE, IRQ_LINE, IRQ_DATA, IRQ_TIMEOUT);
  - flag bit indices;
  - trigger-level decode constants (1, 4, 8, 14);
  - the entry width constant (11).
- Sub-module uart_rx_fifo_mem holds storage, pointers, count and full/empty. The controller keeps errCount, sticky bits, timeout and interrupt logic.

Test Plan:
- Push 0x41 (no flags), triggerLevel=0, rxIrqEnable=1 -> dataReady=1, rdData=0x41, irqId=2 one cycle later; readAck -> irq=0 next cycle.
- Push 16 chars, then a 17th with rxWe -> fifoFull=1, 17th dropped, lineStatus[3]=1; with lineIrqEnable=1 -> irqId=1; lsrRead -> lineStatus=0 and irqId=2 (count 16 >= 14).
- Push 0x55 with rxParityError, then 0x66 clean -> fifoErrPending=1, rdFlags=3'b010; pop -> fifoErrPending=0, rdFlags=0.
- With UART_RX_TIMEOUT_EN, triggerLevel=3, push 2 chars, apply 640 ticks -> irqId=3; one readAck -> timeout cleared, irq=0; a further 640 ticks -> irqId=3 again.
- Full FIFO with readAck+rxWe in the same cycle -> count 15, push dropped; empty FIFO with both -> count 1, rdData=new char.
- fifoClear in the same cycle as rxWe with sticky bits set -> count 0, dataReady=0, sticky bits retained; assert reset mid-fill -> all outputs 0 immediately.
